reg_file_2w: RTL

//  Parametrised general-purpose register file for the datapath: DEPTH x DW, two

---
 rtl/reg_file_2w.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/reg_file_2w.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_2w
//  Purpose  : DEPTH x DW general-purpose register file for the datapath.
//             Two combinational read ports, two synchronous write ports
//             (ALU writeback and memory-load writeback). Registers
//             0..NCONST-1 are hardwired to read as their own index; register
//             LS_REG is the load destination and the store-data source.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             wr_en/wr_addr/wr_data - ALU writeback port
//             ld_en/ld_data         - memory-load writeback into LS_REG
//             st_sel                - datB_out sources LS_REG when 1
//             rd_addrA/rd_addrB     - read addresses
//             datA_out/datB_out     - combinational read data
//             written               - per-register "written since reset" mask
//             wr_conflict           - one-cycle pulse: load and ALU collided
//             ro_err                - sticky: write to a constant register
//  Config   : `define BYPASS_EN to forward same-cycle accepted write data to
//             the read ports; otherwise reads return pre-edge contents.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_2w #(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter int NCONST = 2,
    parameter int LS_REG = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 ld_en,
    input  logic [DW-1:0]        ld_data,
    input  logic                 st_sel,
    input  logic [AW-1:0]        rd_addrA,
    input  logic [AW-1:0]        rd_addrB,
    output logic [DW-1:0]        datA_out,
    output logic [DW-1:0]        datB_out,
    output logic [(2**AW)-1:0]   written,
    output logic                 wr_conflict,
    output logic                 ro_err
);

    localparam int          c_DEPTH    = 2**AW;
    localparam logic [AW-1:0] c_LS_ADDR  = AW'(LS_REG);
    localparam logic [AW-1:0] c_NC_ADDR  = AW'(NCONST);

    logic [DW-1:0]      w_rd_val [c_DEPTH];
    logic [c_DEPTH-1:0] w_written;
    logic               w_ro_hit;
    logic               w_collide;
    logic               w_alu_acc;
    logic [AW-1:0]      w_addrB;
    logic [DW-1:0]      w_datA;
    logic [DW-1:0]      w_datB;
    logic               r_wr_conflict;
    logic               r_ro_err;

    // ALU write to a constant register is rejected; ALU write that lands on
    // LS_REG while a load is in flight loses to the load.
    assign w_ro_hit  = wr_en && (wr_addr < c_NC_ADDR);
    assign w_collide = wr_en && ld_en && (wr_addr == c_LS_ADDR);
    assign w_alu_acc = wr_en && !w_ro_hit && !w_collide;

    genvar gi;
    generate
        for (gi = 0; gi < c_DEPTH; gi++) begin : g_reg
            if (gi < NCONST) begin : g_const
                assign w_rd_val[gi]  = DW'(gi);
                assign w_written[gi] = 1'b0;
            end else begin : g_rw
                localparam bit c_IS_LS = (gi == LS_REG);
                logic [DW-1:0] r_val;
                logic          r_wr;
                logic          w_ld_hit;
                logic          w_alu_hit;

                assign w_ld_hit  = ld_en && c_IS_LS;
                assign w_alu_hit = w_alu_acc && (wr_addr == AW'(gi));

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_val <= '0;
                        r_wr  <= 1'b0;
                    end else if (w_ld_hit) begin
                        r_val <= ld_data;
                        r_wr  <= 1'b1;
                    end else if (w_alu_hit) begin
                        r_val <= wr_data;
                        r_wr  <= 1'b1;
                    end
                end

                assign w_rd_val[gi]  = r_val;
                assign w_written[gi] = r_wr;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_conflict <= 1'b0;
            r_ro_err      <= 1'b0;
        end else begin
            r_wr_conflict <= w_collide;
            r_ro_err      <= r_ro_err | w_ro_hit;
        end
    end

    assign w_addrB = st_sel ? c_LS_ADDR : rd_addrB;

`ifdef BYPASS_EN
    // Forward only writes that will actually commit at the coming edge;
    // the load port has priority, matching the commit priority.
    always_comb begin
        w_datA = w_rd_val[rd_addrA];
        if (!reset && ld_en && (rd_addrA == c_LS_ADDR))
            w_datA = ld_data;
        else if (!reset && w_alu_acc && (rd_addrA == wr_addr))
            w_datA = wr_data;
    end

    always_comb begin
        w_datB = w_rd_val[w_addrB];
        if (!reset && ld_en && (w_addrB == c_LS_ADDR))
            w_datB = ld_data;
        else if (!reset && w_alu_acc && (w_addrB == wr_addr))
            w_datB = wr_data;
    end
`else
    assign w_datA = w_rd_val[rd_addrA];
    assign w_datB = w_rd_val[w_addrB];
`endif

    assign datA_out    = w_datA;
    assign datB_out    = w_datB;
    assign written     = w_written;
    assign wr_conflict = r_wr_conflict;
    assign ro_err      = r_ro_err;

endmodule
`default_nettype wire
